// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared RISC-V pipeline definitions: ALU op codes, field widths and the
// packed control bundle carried from ID to EX.
package id_ex_pipeline_register_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  localparam int FUNCT_W   = 4;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 8;

  // All-zero value is a NOP, so a bubble is simply '0.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  typedef enum logic [1:0] {
    XFER_LOAD   = 2'b00,
    XFER_HOLD   = 2'b01,
    XFER_BUBBLE = 2'b10
  } xfer_e;

  // Priority: flush > stall > load; an invalid ID slot becomes a bubble.
  function automatic xfer_e sel_xfer(input logic flush, input logic stall,
                                     input logic id_valid);
    if (flush)         return XFER_BUBBLE;
    else if (stall)    return XFER_HOLD;
    else if (id_valid) return XFER_LOAD;
    else               return XFER_BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_pipeline_register_sat_counter.sv
// Saturating up-counter used for the ID/EX bubble and stall statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decoded control, operands and indices,
// with stall hold, flush/bubble insertion and saturating performance counters.
module id_ex_pipeline_register
  import id_ex_pipeline_register_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [1:0]           id_alu_op,
  input  logic [FUNCT_W-1:0]   id_funct,
  input  logic                 id_alu_src,
  input  logic                 id_branch,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_reg_write,
  input  logic                 id_mem_to_reg,
  input  logic [DATA_W-1:0]    id_pc,
  input  logic [DATA_W-1:0]    id_rs1_data,
  input  logic [DATA_W-1:0]    id_rs2_data,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  output logic                 ex_valid,
  output logic [1:0]           ex_alu_op,
  output logic [FUNCT_W-1:0]   ex_funct,
  output logic                 ex_alu_src,
  output logic                 ex_branch,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_reg_write,
  output logic                 ex_mem_to_reg,
  output logic [DATA_W-1:0]    ex_pc,
  output logic [DATA_W-1:0]    ex_rs1_data,
  output logic [DATA_W-1:0]    ex_rs2_data,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [CNT_W-1:0]     bubble_count,
  output logic [CNT_W-1:0]     stall_count
);

  ctrl_t                w_id_ctrl;
  xfer_e                w_xfer;
  logic                 w_bubble_inc;
  logic                 w_stall_inc;

  ctrl_t                r_ctrl;
  logic                 r_valid;
  logic [FUNCT_W-1:0]   r_funct;
  logic [DATA_W-1:0]    r_pc;
  logic [DATA_W-1:0]    r_rs1_data;
  logic [DATA_W-1:0]    r_rs2_data;
  logic [DATA_W-1:0]    r_imm;
  logic [REG_IDX_W-1:0] r_rs1;
  logic [REG_IDX_W-1:0] r_rs2;
  logic [REG_IDX_W-1:0] r_rd;

  always_comb begin
    w_id_ctrl            = '0;
    w_id_ctrl.alu_op     = id_alu_op;
    w_id_ctrl.alu_src    = id_alu_src;
    w_id_ctrl.branch     = id_branch;
    w_id_ctrl.mem_read   = id_mem_read;
    w_id_ctrl.mem_write  = id_mem_write;
    w_id_ctrl.reg_write  = id_reg_write;
    w_id_ctrl.mem_to_reg = id_mem_to_reg;
  end

  assign w_xfer       = sel_xfer(flush, stall, id_valid);
  assign w_bubble_inc = (w_xfer == XFER_BUBBLE);
  assign w_stall_inc  = (w_xfer == XFER_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_funct    <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else begin
      case (w_xfer)
        XFER_LOAD: begin
          r_valid    <= 1'b1;
          r_ctrl     <= w_id_ctrl;
          r_funct    <= id_funct;
          r_pc       <= id_pc;
          r_rs1_data <= id_rs1_data;
          r_rs2_data <= id_rs2_data;
          r_imm      <= id_imm;
          r_rs1      <= id_rs1;
          r_rs2      <= id_rs2;
          r_rd       <= id_rd;
        end
        XFER_BUBBLE: begin
          r_valid    <= 1'b0;
          r_ctrl     <= '0;
          r_funct    <= '0;
          r_pc       <= '0;
          r_rs1_data <= '0;
          r_rs2_data <= '0;
          r_imm      <= '0;
          r_rs1      <= '0;
          r_rs2      <= '0;
          r_rd       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_funct      = r_funct;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_pc         = r_pc;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bubble_inc),
    .count (bubble_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (stall_count)
  );

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Scoreboard bench for id_ex_pipeline_register: driver pushes model results,
// monitor pops and compares one record per rising edge.
module tb_id_ex_pipeline_register;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic [3:0]        funct;
    logic              alu_src;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CNT_W-1:0]  bcnt;
    logic [CNT_W-1:0]  scnt;
  } ex_t;

  logic clk = 1'b0;
  logic reset, stall, flush, id_valid;
  logic [1:0] id_alu_op;
  logic [3:0] id_funct;
  logic id_alu_src, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_valid;
  logic [1:0] ex_alu_op;
  logic [3:0] ex_funct;
  logic ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [DATA_W-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0] bubble_count, stall_count;

  int tests = 0;
  int fails = 0;
  int txn   = 0;
  ex_t model;
  ex_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_pipeline_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .bubble_count(bubble_count), .stall_count(stall_count)
  );

  function automatic ex_t dut_state();
    ex_t s;
    s = '{valid: ex_valid, alu_op: ex_alu_op, funct: ex_funct, alu_src: ex_alu_src,
          branch: ex_branch, mem_read: ex_mem_read, mem_write: ex_mem_write,
          reg_write: ex_reg_write, mem_to_reg: ex_mem_to_reg, pc: ex_pc,
          rs1_data: ex_rs1_data, rs2_data: ex_rs2_data, imm: ex_imm,
          rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, bcnt: bubble_count, scnt: stall_count};
    return s;
  endfunction

  // Reference: what EX should hold after the coming edge, from the ID-side rules.
  task automatic commit();
    int b, s;
    b = int'(model.bcnt);
    s = int'(model.scnt);
    if (reset) begin
      model = '0;
    end else if (flush || (!stall && !id_valid)) begin
      model = '0;
      model.bcnt = CNT_W'((b < CNT_MAX) ? b + 1 : b);
      model.scnt = CNT_W'(s);
    end else if (stall) begin
      model.scnt = CNT_W'((s < CNT_MAX) ? s + 1 : s);
    end else begin
      model = '{valid: 1'b1, alu_op: id_alu_op, funct: id_funct, alu_src: id_alu_src,
                branch: id_branch, mem_read: id_mem_read, mem_write: id_mem_write,
                reg_write: id_reg_write, mem_to_reg: id_mem_to_reg, pc: id_pc,
                rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                rs1: id_rs1, rs2: id_rs2, rd: id_rd, bcnt: CNT_W'(b), scnt: CNT_W'(s)};
    end
    exp_q.push_back(model);
  endtask

  task automatic rand_id();
    id_alu_op     = 2'($urandom_range(0, 2));
    id_funct      = 4'($urandom);
    id_alu_src    = 1'($urandom);
    id_branch     = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_reg_write  = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
    id_pc         = {$urandom, $urandom};
    id_rs1_data   = {$urandom, $urandom};
    id_rs2_data   = {$urandom, $urandom};
    id_imm        = {$urandom, $urandom};
    id_rs1        = 5'($urandom);
    id_rs2        = 5'($urandom);
    id_rd         = 5'($urandom);
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic v);
    @(negedge clk);
    rand_id();
    reset = r; stall = s; flush = f; id_valid = v;
    commit();
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, req);
    end
  endtask

  // Monitor: the register presents a new EX record after every rising edge.
  initial begin
    ex_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = dut_state();
        txn++;
        check("ctrl", 256'({a.valid, a.alu_op, a.funct, a.alu_src, a.branch, a.mem_read,
                            a.mem_write, a.reg_write, a.mem_to_reg}),
                      256'({e.valid, e.alu_op, e.funct, e.alu_src, e.branch, e.mem_read,
                            e.mem_write, e.reg_write, e.mem_to_reg}));
        check("pc_rs1", {a.pc, a.rs1_data, 128'd0}, {e.pc, e.rs1_data, 128'd0});
        check("rs2_imm", {a.rs2_data, a.imm, 128'd0}, {e.rs2_data, e.imm, 128'd0});
        check("idx", 256'({a.rs1, a.rs2, a.rd}), 256'({e.rs1, e.rs2, e.rd}));
        check("bubble_count", 256'(a.bcnt), 256'(e.bcnt));
        check("stall_count", 256'(a.scnt), 256'(e.scnt));
        $display("[TB] txn %0d valid=%0b alu_op=%0b rd=%0d bubbles=%0d stalls=%0d",
                 txn, a.valid, a.alu_op, a.rd, a.bcnt, a.scnt);
      end
    end
  end

  initial begin
    model = '0;
    rand_id();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    commit();
    step(1, 0, 0, 0);

    // Directed load: R-type sub into x5.
    @(negedge clk);
    rand_id();
    reset = 0; stall = 0; flush = 0; id_valid = 1;
    id_alu_op = 2'b10; id_funct = 4'b1000; id_rd = 5'd5; id_rs1_data = 64'd7;
    commit();

    repeat (3) step(0, 1, 0, 1);   // stall with changing ID inputs
    @(negedge clk);
    rand_id();
    reset = 0; stall = 1; flush = 1; id_valid = 1; id_reg_write = 1'b1;
    commit();
    repeat (2) step(0, 0, 0, 0);   // invalid ID slots become bubbles
    step(0, 0, 0, 1);

    // Async reset pulse between edges while EX holds a valid instruction.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 256'(dut_state()), 256'd0);
    #1 reset = 1'b0;
    model = '0;
    rand_id();
    stall = 0; flush = 0; id_valid = 1;
    commit();

    repeat (20) step(0, 1, 0, 0);  // long stall saturates the narrow counter
    repeat (20) step(0, 0, 1, 1);  // flushes saturate the bubble counter

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0));
    end

    @(posedge clk);
    #2;
    check("queue_drained", 256'(exp_q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
